pc_fetch: RTL
=============

# pc_fetch

Fetch-stage program counter and instruction-memory requester. Holds the architectural fetch PC and presents the sequential next PC (`pc + 4`) to the pipeline-reset stage. It takes that stage's selected next PC back on `npc`, alongside the `flush` redirect. It issues one request at a time to instruction memory and hands each fetched word downstream with a valid/stall handshake.

## Interface
Clock and reset: one clock; reset is asynchronous and active-high.

Parameters
- `WordSize`, default 32: address and instruction width.
- `ResetVector`, default 0: PC value loaded on reset.

Ports
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `npc_seq`  out  WordSize  `pc + 4`, combinational; feeds the pipeline-reset stage's sequential-PC input.
- `npc`  in  WordSize  selected next PC returned by the pipeline-reset stage (either `npc_seq` or the corrected target).
- `flush`  in  1  redirect; same signal that drives the pipeline-reset stage.
- `stall`  in  1  downstream cannot accept `instr_out` this cycle.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  WordSize  request address; stable while `imem_req` is high and not yet acked.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; may assert in the first cycle of a request.
- `imem_rdata`  in  WordSize  instruction word, valid when `imem_ack` is high.
- `instr_valid`  out  1  `instr_out`/`pc_out` hold a live instruction.
- `instr_out`  out  WordSize  fetched instruction.
- `pc_out`  out  WordSize  address of `instr_out`.

## Operation
- Registers: `pc`, `req_addr`, `instr_out`, `pc_out`, and a 2-bit state.
- States:
  - IDLE: post-reset only.
  - FETCH: request outstanding for the current `pc`.
  - DRAIN: stale request outstanding after a flush.
  - VALID: instruction held for downstream.
- Outputs by state:
  - `imem_req` = state is FETCH or DRAIN.
  - `imem_addr` = `req_addr`.
  - `instr_valid` = state is VALID.
- IDLE: go to FETCH and set `req_addr = pc`.
- FETCH:
  - `flush` with `imem_ack`: discard data, `pc <= npc`, `req_addr <= npc`, stay in FETCH.
  - `flush` without `imem_ack`: `pc <= npc`, keep `req_addr`, go to DRAIN.
  - `imem_ack` without `flush`: `instr_out <= imem_rdata`, `pc_out <= req_addr`, go to VALID.
  - Otherwise: hold.
- DRAIN:
  - `imem_ack`: discard data, set `req_addr = pc`, go to FETCH.
  - `flush` (with or without `imem_ack`): `pc <= npc`; the latest flush wins.
- VALID:
  - `flush`: `pc <= npc`, `req_addr <= npc`, go to FETCH. `flush` overrides `stall`; the held instruction is dropped.
  - `!stall`: instruction is consumed; `pc <= npc` (equals `npc_seq` because `flush` is 0), `req_addr <= npc`, go to FETCH.
  - `stall`: hold all registers.
- `npc` is sampled only on an advance (VALID with `!stall`) or a flush; all other cycles ignore it.
- PC arithmetic is modulo 2^WordSize: `npc_seq` wraps from `'hFFFF_FFFC` to 0. No alignment check is performed.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, `pc` = `req_addr` = `ResetVector`.
  - `instr_out` = `pc_out` = 0, `instr_valid` = 0, `imem_req` = 0.
  - `npc_seq` = `ResetVector + 4`.
- First `imem_req` is high in the second cycle after `rst` falls (IDLE lasts one cycle).
- Zero-wait memory (ack in the first request cycle): `instr_valid` rises the cycle after ack. Throughput is one instruction per 2 cycles.
- N wait cycles add N cycles per instruction.
- Once raised, `imem_req` and `imem_addr` are held until the ack cycle, including across a flush (DRAIN). A request is never withdrawn.
- Reset asserted mid-request abandons the request. Memory must tolerate this.
- `instr_valid` falls in the cycle after a consumed or flushed VALID.

## Test plan
- Reset release, `ResetVector`=`'h100`, zero-wait memory, no stall:
  - `imem_addr` sequence is `'h100`, `'h104`, `'h108`.
  - `instr_valid` pulses every other cycle.
  - `pc_out` matches each address.
- Stall held for 3 cycles in VALID at `pc_out`=`'h104`:
  - `instr_valid` stays 1 and `instr_out` stays stable.
  - No `imem_req` during the stall.
  - Next request is `'h108`.
- Flush with `npc`=`'h200` during a 3-wait-cycle request to `'h10C`:
  - `imem_req`/`addr` remain at `'h10C` until ack.
  - Returned data is dropped (`instr_valid` stays 0).
  - Next request is `'h200`.
- Flush plus stall in VALID with `npc`=`'h300`:
  - `instr_valid` is 0 the next cycle.
  - Next request is `'h300`.
- Wrap: `ResetVector`=`'hFFFF_FFFC`:
  - `npc_seq`=0; the second request address is 0.
- Async reset asserted mid-DRAIN:
  - All outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: fetch-stage PC with single-outstanding instruction-memory requester
module pc_fetch #(
  parameter int                  WordSize    = 32,
  parameter logic [WordSize-1:0] ResetVector = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [WordSize-1:0] npc_seq,
  input  logic [WordSize-1:0] npc,
  input  logic                flush,
  input  logic                stall,
  output logic                imem_req,
  output logic [WordSize-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WordSize-1:0] imem_rdata,
  output logic                instr_valid,
  output logic [WordSize-1:0] instr_out,
  output logic [WordSize-1:0] pc_out
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_e;
  state_e              state_q;
  logic [WordSize-1:0] pc_q, req_addr_q, instr_q, pc_out_q;
  assign npc_seq     = pc_q + WordSize'(4);
  assign imem_req    = state_q == FETCH || state_q == DRAIN;
  assign imem_addr   = req_addr_q;
  assign instr_valid = state_q == VALID;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= ResetVector;
      req_addr_q <= ResetVector;
      instr_q    <= '0;
      pc_out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_addr_q <= pc_q;
          state_q    <= FETCH;
        end
        FETCH: begin
          if (flush) begin
            pc_q <= npc;
            if (imem_ack) req_addr_q <= npc;
            else state_q <= DRAIN;
          end else if (imem_ack) begin
            instr_q  <= imem_rdata;
            pc_out_q <= req_addr_q;
            state_q  <= VALID;
          end
        end
        DRAIN: begin
          // the stale request must complete; the newest redirect target is fetched next
          if (flush) pc_q <= npc;
          if (imem_ack) begin
            req_addr_q <= flush ? npc : pc_q;
            state_q    <= FETCH;
          end
        end
        default: begin
          if (flush || !stall) begin
            pc_q       <= npc;
            req_addr_q <= npc;
            state_q    <= FETCH;
          end
        end
      endcase
    end
  end
endmodule
